// File: rtl/pattern_serializer.sv
// Serial transmitter: shifts one of four 5-bit patterns MSB-first, repeats it
// a latched number of times with an optional idle gap, and counts sent frames.
module pattern_serializer #(
  parameter int unsigned GAP_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       pattern_sel,
  input  logic [7:0]       repeat_count,
  input  logic [GAP_W-1:0] gap_len,
  output logic             serial_out,
  output logic             frame_start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_count
);

  localparam int unsigned PAT_W = 5;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   bit_idx, bit_idx_n;
  logic [1:0]         pat_sh, pat_sh_n;
  logic [7:0]         frames_left, frames_left_n;
  logic [GAP_W-1:0]   gap_sh, gap_sh_n;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
  logic               serial_n, frame_start_n, busy_n, done_n;
  logic [CNT_W-1:0]   sent_count_n;
  logic [PAT_W-1:0]   cur_pat, new_pat;

  function automatic logic [PAT_W-1:0] pattern_bits(input logic [1:0] sel);
    case (sel)
      2'b00:   pattern_bits = 5'b10111;
      2'b01:   pattern_bits = 5'b11010;
      2'b10:   pattern_bits = 5'b01101;
      default: pattern_bits = 5'b10011;
    endcase
  endfunction

  assign cur_pat = pattern_bits(pat_sh);
  assign new_pat = pattern_bits(pattern_sel);

  // State, shadow and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      bit_idx     <= '0;
      pat_sh      <= '0;
      frames_left <= '0;
      gap_sh      <= '0;
      gap_cnt     <= '0;
      serial_out  <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sent_count  <= '0;
    end else begin
      state       <= state_n;
      bit_idx     <= bit_idx_n;
      pat_sh      <= pat_sh_n;
      frames_left <= frames_left_n;
      gap_sh      <= gap_sh_n;
      gap_cnt     <= gap_cnt_n;
      serial_out  <= serial_n;
      frame_start <= frame_start_n;
      busy        <= busy_n;
      done        <= done_n;
      sent_count  <= sent_count_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n       = state;
    bit_idx_n     = bit_idx;
    pat_sh_n      = pat_sh;
    frames_left_n = frames_left;
    gap_sh_n      = gap_sh;
    gap_cnt_n     = gap_cnt;
    serial_n      = 1'b0;
    frame_start_n = 1'b0;
    busy_n        = 1'b0;
    done_n        = 1'b0;
    sent_count_n  = sent_count;

    case (state)
      IDLE: begin
        if (start && (repeat_count != 8'd0)) begin
          pat_sh_n      = pattern_sel;
          frames_left_n = repeat_count;
          gap_sh_n      = gap_len;
          state_n       = SEND;
          bit_idx_n     = IDX_W'(4);
          serial_n      = new_pat[4];
          frame_start_n = 1'b1;
          busy_n        = 1'b1;
        end
      end
      SEND: begin
        busy_n = 1'b1;
        if (bit_idx != '0) begin
          bit_idx_n = bit_idx - IDX_W'(1);
          serial_n  = cur_pat[bit_idx - IDX_W'(1)];
        end else begin
          sent_count_n  = sent_count + CNT_W'(1);
          frames_left_n = frames_left - 8'd1;
          if (frames_left == 8'd1) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else if (gap_sh != '0) begin
            state_n   = GAP;
            gap_cnt_n = gap_sh;
          end else begin
            bit_idx_n     = IDX_W'(4);
            serial_n      = cur_pat[4];
            frame_start_n = 1'b1;
          end
        end
      end
      GAP: begin
        busy_n = 1'b1;
        // gap_cnt == 1 marks the final idle cycle; next edge issues the MSB
        if (gap_cnt == GAP_W'(1)) begin
          state_n       = SEND;
          bit_idx_n     = IDX_W'(4);
          serial_n      = cur_pat[4];
          frame_start_n = 1'b1;
        end else begin
          gap_cnt_n = gap_cnt - GAP_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/pattern_serializer.md
# pattern_serializer

Serial transmitter for the 2-bit-selected 5-bit pattern set used by the sequence-detection path. It shifts the selected pattern MSB-first onto a one-bit line, repeats it a programmed number of times with an optional idle gap between frames, and counts completed frames. Its serial output drives the detector's serial input directly, so detector benches can use known frame streams instead of random stimulus.

## Interface
Parameters:
- GAP_W, 4, width of the gap-length input
- CNT_W, 16, width of the sent-frame counter

Ports:
- clk  input  1  rising-edge clock, the only clock
- reset  input  1  asynchronous, active-low; 0 clears all state immediately
- start  input  1  request to begin a burst; sampled only in IDLE
- pattern_sel  input  2  pattern select: 00=10111, 01=11010, 10=01101, 11=10011
- repeat_count  input  8  frames per burst; 0 = request ignored
- gap_len  input  GAP_W  idle cycles (serial_out=0) between frames of a burst
- serial_out  output  1  serial data, MSB of pattern first
- frame_start  output  1  high during the cycle the MSB of each frame is on serial_out
- busy  output  1  high from the first bit of the burst through the last bit
- done  output  1  one-cycle pulse after the burst's final bit
- sent_count  output  CNT_W  total completed frames since reset

## Operation
- States: IDLE, SEND, GAP.
- IDLE: serial_out=0, busy=0. At an edge with start=1 and repeat_count!=0:
  - latch pattern_sel, repeat_count and gap_len into shadow registers;
  - enter SEND with the bit index at 4;
  - drive serial_out=pattern[4], frame_start=1, busy=1 (all registered at that edge).
- SEND: each edge advances the bit index 4→0. At the edge leaving bit 0:
  - sent_count increments and frames_left decrements.
  - If frames remain and gap_len>0: go to GAP and load a gap counter with gap_len.
  - If frames remain and gap_len=0: start the next frame back-to-back (MSB, frame_start=1).
  - If no frames remain: go to IDLE with serial_out=0, busy=0, done=1 for one cycle.
- GAP: serial_out=0, busy=1 for exactly gap_len cycles. The next frame then starts with frame_start=1.
- start, pattern_sel, repeat_count and gap_len changes during busy are ignored. A burst always uses its latched values.
- Start with repeat_count=0: no state change, no done pulse.
- sent_count wraps from 2^CNT_W-1 to 0 without any flag.
- Burst length in cycles: 5·R + (R−1)·gap_len.

## Timing
- Reset (reset=0, asynchronous) forces:
  - serial_out=0, frame_start=0, busy=0, done=0, sent_count=0;
  - state=IDLE; shadow registers cleared.
- Reset mid-burst aborts the burst with no done pulse. The partial frame is not counted.
- After reset is released, the first start is sampled at the first rising edge with reset=1.
- All outputs are registered; no combinational path from inputs to outputs.
- Latency: serial_out carries the MSB in the cycle immediately after the edge that samples start.
- done is high in the cycle after the last bit and coincides with busy=0.
- start held high at the done edge is not sampled; the earliest new burst begins at the following edge, i.e. one idle cycle minimum between bursts.
- frame_start is high for exactly one cycle per frame.

## Test plan
- Reset, then start with sel=00, R=1, gap=0 at edge N:
  - serial_out=1,0,1,1,1 in cycles N+1..N+5, frame_start high only in N+1;
  - done high and busy low in N+6; sent_count=1.
- sel=01, R=2, gap=2:
  - serial_out=1,1,0,1,0,0,0,1,1,0,1,0; busy high for 12 cycles;
  - frame_start high in cycles 1 and 8; done once; sent_count goes +2.
- sel=11, R=3, gap=0:
  - 15 contiguous bits 10011 10011 10011, frame_start in cycles 1, 6, 11; sent_count +3.
- During a burst (sel=10, R=2, gap=1), toggle start and change sel to 00 and R to 9:
  - stream stays 01101 0 01101; exactly 2 frames; one done.
- Start with R=0: busy, done and serial_out stay 0; sent_count unchanged.
- Drop reset low mid-way through frame 2 of an R=4 burst:
  - all outputs go 0 immediately, sent_count=0, no done;
  - a new start after release runs normally.
